// File: rtl/load_store_unit.sv
// Load/store sequencer between the memory stage and a word-wide data memory.
// Sub-word stores do a read-modify-write. Loads are sign- or zero-extended.
module load_store_unit (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    output logic        ready_o,
    input  logic        we_i,
    input  logic [1:0]  size_i,
    input  logic        uns_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] rdata_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    output logic        mem_we_o,
    input  logic [31:0] mem_rd_i
);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_RESP
    } state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] a_q, a_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [31:0] hold_q, hold_d;
    logic [31:0] rdata_q, rdata_d;

    logic        accept;
    logic        bad_req;
    logic [31:0] l_word;
    logic [31:0] wr_word;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;

    assign accept  = req_i && (state_q == S_IDLE);
    assign bad_req = (size_i == 2'b11)
                  || ((size_i == SZ_HALF) && addr_i[0])
                  || ((size_i == SZ_WORD) && (addr_i[1:0] != 2'b00));

    // Memory returns the lowest-addressed byte in the top lane; swap so that
    // lane k of l_word holds byte A+k.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_swap
            assign l_word[8*gi +: 8] = mem_rd_i[8*(3-gi) +: 8];
        end
    endgenerate

    // Write word: full store data for word stores, otherwise the captured
    // read word with the addressed lane(s) replaced.
    generate
        for (gi = 0; gi < 4; gi++) begin : g_merge
            logic lane_hit;
            assign lane_hit = (size_q == SZ_BYTE) ? (a_q[1:0] == 2'(gi))
                                                  : (a_q[1] == 1'(gi / 2));
            always_comb begin
                if (size_q == SZ_WORD) begin
                    wr_word[8*gi +: 8] = wdata_q[8*gi +: 8];
                end else if (lane_hit) begin
                    wr_word[8*gi +: 8] = (size_q == SZ_BYTE) ? wdata_q[7:0]
                                                             : wdata_q[8*(gi%2) +: 8];
                end else begin
                    wr_word[8*gi +: 8] = hold_q[8*gi +: 8];
                end
            end
        end
    endgenerate

    assign byte_sel = l_word[{a_q[1:0], 3'b000} +: 8];
    assign half_sel = l_word[{a_q[1], 4'b0000} +: 16];

    always_comb begin
        load_ext = l_word;
        case (size_q)
            SZ_BYTE: load_ext = {{24{~uns_q & byte_sel[7]}}, byte_sel};
            SZ_HALF: load_ext = {{16{~uns_q & half_sel[15]}}, half_sel};
            default: load_ext = l_word;
        endcase
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        a_d     = a_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        hold_d  = hold_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    we_d    = we_i;
                    size_d  = size_i;
                    uns_d   = uns_i;
                    a_d     = addr_i;
                    wdata_d = wdata_i;
                    err_d   = bad_req;
                    if (bad_req) begin
                        state_d = S_RESP;
                    end else if (we_i && (size_i == SZ_WORD)) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                hold_d = l_word;
                if (we_q) begin
                    state_d = S_WR;
                end else begin
                    rdata_d = load_ext;
                    state_d = S_RESP;
                end
            end
            S_WR: begin
                state_d = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            a_q     <= 32'h0;
            wdata_q <= 32'h0;
            err_q   <= 1'b0;
            hold_q  <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            a_q     <= a_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            hold_q  <= hold_d;
            rdata_q <= rdata_d;
        end
    end

    assign ready_o    = (state_q == S_IDLE);
    assign done_o     = (state_q == S_RESP);
    assign err_o      = (state_q == S_RESP) && err_q;
    assign mem_we_o   = (state_q == S_WR);
    assign mem_wd_o   = (state_q == S_WR) ? wr_word : 32'h0;
    assign mem_addr_o = {a_q[31:2], 2'b00};
    assign rdata_o    = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-array memory model and an
// expected-result queue popped at each done pulse.
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        req;
    logic        ready;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [31:0] mem_rd;

    logic [7:0]  mem [0:255];

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          we_cnt;
        logic [31:0] wd;
        logic [31:0] maddr;
    } exp_t;

    exp_t exp_q[$];

    load_store_unit dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_i      (req),
        .ready_o    (ready),
        .we_i       (we),
        .size_i     (size),
        .uns_i      (uns),
        .addr_i     (addr),
        .wdata_i    (wdata),
        .done_o     (done),
        .err_o      (err),
        .rdata_o    (rdata),
        .mem_addr_o (mem_addr),
        .mem_wd_o   (mem_wd),
        .mem_we_o   (mem_we),
        .mem_rd_i   (mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Lowest-addressed byte in the top lane on read, in the bottom lane on write.
    always_comb begin
        mem_rd = {mem[mem_addr[7:0]], mem[8'(mem_addr[7:0] + 8'd1)],
                  mem[8'(mem_addr[7:0] + 8'd2)], mem[8'(mem_addr[7:0] + 8'd3)]};
    end

    always @(posedge clk) begin
        if (mem_we) begin
            for (int k = 0; k < 4; k++) begin
                mem[8'(mem_addr[7:0] + 8'(k))] <= mem_wd[8*k +: 8];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Issue one request at a negedge, wait for done, compare with the popped
    // expectation.
    task automatic run(input string tag, input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd, input logic e_err,
                       input logic [31:0] e_rdata, input int e_lat, input int e_we_cnt,
                       input logic [31:0] e_wd);
        exp_t e;
        exp_t got_e;
        int   cycles;
        int   we_cnt;
        logic got;
        logic [31:0] seen_wd;
        e.err = e_err; e.rdata = e_rdata; e.lat = e_lat; e.we_cnt = e_we_cnt;
        e.wd = e_wd; e.maddr = {a[31:2], 2'b00};
        check({tag, ".ready"}, 32'(ready), 32'd1);
        exp_q.push_back(e);
        req = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = wd;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0; we = 1'b0; size = 2'b00; uns = 1'b0; addr = 32'hDEAD_BEEF; wdata = 32'h5A5A_5A5A;
        cycles = 1; we_cnt = 0; got = 1'b0; seen_wd = 32'h0;
        while (!got && cycles <= 8) begin
            if (mem_we) begin
                we_cnt++;
                seen_wd = mem_wd;
            end
            if (done) begin
                got = 1'b1;
            end else begin
                @(negedge clk);
                cycles++;
            end
        end
        got_e = exp_q.pop_front();
        check({tag, ".done_seen"}, 32'(got), 32'd1);
        check({tag, ".latency"}, 32'(cycles), 32'(got_e.lat));
        check({tag, ".err"}, 32'(err), 32'(got_e.err));
        check({tag, ".rdata"}, rdata, got_e.rdata);
        check({tag, ".mem_we_cycles"}, 32'(we_cnt), 32'(got_e.we_cnt));
        if (got_e.we_cnt > 0) begin
            check({tag, ".mem_wd"}, seen_wd, got_e.wd);
        end
        if (!got_e.err) begin
            check({tag, ".mem_addr"}, mem_addr, got_e.maddr);
        end
        $display("txn %-12s we=%0d size=%0d addr=%h lat=%0d err=%0d rdata=%h",
                 tag, w, sz, a, cycles, err, rdata);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; uns = 1'b0;
        addr = 32'h0; wdata = 32'h0;
        @(negedge clk);
        check("rst.ready", 32'(ready), 32'd1);
        check("rst.done", 32'(done), 32'd0);
        check("rst.err", 32'(err), 32'd0);
        check("rst.rdata", rdata, 32'h0);
        check("rst.mem_we", 32'(mem_we), 32'd0);
        check("rst.mem_addr", mem_addr, 32'h0);
        check("rst.mem_wd", mem_wd, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        //   tag            we    size   uns   addr         wdata          err   rdata          lat we wd
        run("st_w_10",     1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344, 1'b0, 32'h0000_0000, 2, 1, 32'h1122_3344);
        run("ld_b_11",     1'b0, 2'b00, 1'b0, 32'h11, 32'h0,         1'b0, 32'h0000_0033, 2, 0, 32'h0);
        run("st_b_12",     1'b1, 2'b00, 1'b0, 32'h12, 32'h0000_00AA, 1'b0, 32'h0000_0033, 3, 1, 32'h11AA_3344);
        run("ld_w_10",     1'b0, 2'b10, 1'b0, 32'h10, 32'h0,         1'b0, 32'h11AA_3344, 2, 0, 32'h0);
        run("ld_b_12s",    1'b0, 2'b00, 1'b0, 32'h12, 32'h0,         1'b0, 32'hFFFF_FFAA, 2, 0, 32'h0);
        run("ld_b_12u",    1'b0, 2'b00, 1'b1, 32'h12, 32'h0,         1'b0, 32'h0000_00AA, 2, 0, 32'h0);
        run("st_h_12",     1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_BEEF, 1'b0, 32'h0000_00AA, 3, 1, 32'hBEEF_3344);
        run("ld_h_12s",    1'b0, 2'b01, 1'b0, 32'h12, 32'h0,         1'b0, 32'hFFFF_BEEF, 2, 0, 32'h0);
        run("ld_h_12u",    1'b0, 2'b01, 1'b1, 32'h12, 32'h0,         1'b0, 32'h0000_BEEF, 2, 0, 32'h0);
        run("ld_h_10s",    1'b0, 2'b01, 1'b0, 32'h10, 32'h0,         1'b0, 32'h0000_3344, 2, 0, 32'h0);
        run("ld_w_10b",    1'b0, 2'b10, 1'b0, 32'h10, 32'h0,         1'b0, 32'hBEEF_3344, 2, 0, 32'h0);
        run("err_ld_h_11", 1'b0, 2'b01, 1'b0, 32'h11, 32'h0,         1'b1, 32'hBEEF_3344, 1, 0, 32'h0);
        run("err_st_w_12", 1'b1, 2'b10, 1'b0, 32'h12, 32'hCAFE_F00D, 1'b1, 32'hBEEF_3344, 1, 0, 32'h0);
        run("err_size11",  1'b1, 2'b11, 1'b0, 32'h10, 32'h1234_5678, 1'b1, 32'hBEEF_3344, 1, 0, 32'h0);
        check("mem.after_err", {mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13]}, 32'h4433_EFBE);

        // Reset while a byte store sits in RD: nothing may be written.
        req = 1'b1; we = 1'b1; size = 2'b00; uns = 1'b0; addr = 32'h13; wdata = 32'h0000_0077;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        check("mid.in_rd_ready", 32'(ready), 32'd0);
        rst = 1'b1;
        #1;
        check("mid.ready", 32'(ready), 32'd1);
        check("mid.done", 32'(done), 32'd0);
        check("mid.err", 32'(err), 32'd0);
        check("mid.rdata", rdata, 32'h0);
        check("mid.mem_we", 32'(mem_we), 32'd0);
        check("mid.mem_addr", mem_addr, 32'h0);
        check("mid.mem_wd", mem_wd, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("mid.post_done", 32'(done), 32'd0);
            check("mid.post_we", 32'(mem_we), 32'd0);
        end
        check("mid.mem13", 32'(mem[8'h13]), 32'h0000_00BE);
        $display("txn %-12s reset during RD, byte 0x13=%h", "rst_mid_st", mem[8'h13]);

        run("ld_w_after",  1'b0, 2'b10, 1'b0, 32'h10, 32'h0,         1'b0, 32'hBEEF_3344, 2, 0, 32'h0);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sequencer between the pipeline's memory stage and the byte-addressed, word-wide data memory. It turns byte, halfword and word loads and stores into aligned word accesses. Loads are sign- or zero-extended. Sub-word stores use a read-modify-write sequence, and misaligned requests are rejected without touching memory. The memory-side ports connect directly to the data memory's `addr`/`wd`/`we`/`rd`.

## Interface
- (no parameters)
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req`  in  1  request valid; accepted on an edge where `req && ready`
- `ready`  out  1  unit idle, can accept a request
- `we`  in  1  1 = store, 0 = load
- `size`  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- `uns`  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- `addr`  in  32  byte address
- `wdata`  in  32  store data, right-justified (byte in [7:0], half in [15:0])
- `done`  out  1  one-cycle completion pulse
- `err`  out  1  valid with `done`: request rejected (misaligned or illegal size)
- `rdata`  out  32  load result, valid from the `done` cycle until the next successful load
- `mem_addr`  out  32  word-aligned address `{a_q[31:2],2'b00}`
- `mem_wd`  out  32  write word to memory
- `mem_we`  out  1  memory write enable, high exactly one cycle per store
- `mem_rd`  in  32  combinational read word from memory

## Operation
- **Memory lane contract**
  - Read word at aligned A returns `{m[A],m[A+1],m[A+2],m[A+3]}`.
  - Write places `wd[7:0]`→m[A], `wd[15:8]`→m[A+1], `wd[23:16]`→m[A+2], `wd[31:24]`→m[A+3].
- **Internal word L** = byte-swap of `mem_rd`, so `L[8k+7:8k]` = m[A+k].
  - `mem_wd` is written in L ordering.
  - This makes the lane mapping little-endian end to end.
- **Request latch:** on acceptance, register `we`, `size`, `uns`, `addr`, `wdata` (a_q etc.).
  - Inputs are ignored while `ready=0`.
- **States:** IDLE, RD, WR, RESP. `ready = (state==IDLE)`.
- **IDLE → next state on accept:**
  - size 11, or half with `addr[0]=1`, or word with `addr[1:0]≠0` → RESP with err flag set.
  - Load → RD.
  - Word store → WR.
  - Byte/half store → RD.
- **RD:**
  - Capture L into a holding register.
  - Load → RESP; `rdata` loaded at this edge.
  - Sub-word store → WR.
- **WR:**
  - `mem_we=1`.
  - `mem_wd` = wdata (word store), or the captured L with lane(s) replaced (byte k=a_q[1:0]; half lanes a_q[1]*2, +1).
  - Next state RESP.
- **RESP:** `done=1`, `err` = err flag; next state IDLE.
- **Load extraction:**
  - Byte = `L[8k+7:8k]`.
  - Half = `L[16h+15:16h]`, h=a_q[1].
  - Extend to 32 bits per `uns`.
- **`rdata` update:** only on successful loads; unchanged on stores and errors.
- **`mem_we`:** decoded from state (WR only) and 0 in every other state, including after reset.
- **Errors:** no RD or WR state is visited, so no memory read is consumed and no write is issued.

## Timing
- Acceptance edge = E0.
- **Latency to `done`:**
  - Load: high in cycle after E1 (2 cycles).
  - Word store: `mem_we` in cycle after E0, `done` after E1 (2 cycles).
  - Sub-word store: RD, WR, RESP (3 cycles).
  - Error: `done`/`err` in cycle after E0 (1 cycle).
- `ready` returns high the cycle after RESP, so the maximum throughput is one request per 3/3/4/2 cycles (load / word store / sub-word store / error).
- `mem_addr` is stable from the cycle after E0 through RESP.
- **Reset values:**
  - State IDLE; `ready=1`.
  - `done=0`, `err=0`, `rdata=0`, `mem_we=0`, `mem_addr=0`, `mem_wd=0`.
  - All latched fields 0.
- **Reset mid-operation:** asserting `rst` in any state forces IDLE immediately (asynchronous).
  - `mem_we` drops in the same cycle.
  - An in-flight store whose WR cycle has not completed is not written.
  - No `done` pulse is produced for the aborted request.
- `req` held high across RESP is accepted again on the first IDLE edge; each accepted request yields exactly one `done`.

## Test plan
- **Word store:** word store `wdata=0x11223344` at `addr=0x10`.
  - Required: `mem_we` one cycle, `mem_addr=0x10`, `mem_wd=0x11223344`; `done` 2 cycles after accept, `err=0`.
  - Then byte load signed at 0x11 → `rdata=0x00000033`.
- **Sub-word RMW:** after the above, byte store `wdata=0x000000AA` at 0x12.
  - Required: RD then WR with `mem_wd=0x11AA3344`; `done` 3 cycles after accept.
  - Word load at 0x10 → `0x11AA3344`.
- **Extension:** byte load at 0x12 with `uns=0` → `0xFFFFFFAA`; with `uns=1` → `0x000000AA`.
  - Half store `0xBEEF` at 0x12 then signed half load at 0x12 → `0xFFFFBEEF`; word at 0x10 reads `0xBEEF3344`.
- **Misaligned and illegal:** half load at 0x11, word store at 0x12, `size=11`.
  - Each: `done=1`, `err=1` one cycle after accept; `mem_we` never asserted; `rdata` unchanged.
- **Reset mid-store:** start byte store at 0x13, assert `rst` during RD.
  - Required: `mem_we` never high, `done` never pulses, `ready=1` and all outputs at reset values immediately.
  - Memory byte 0x13 is unchanged.
